// File: rtl/load_align_pkg.sv
// Shared types for the load-align path: FSM states, size encoding and the
// word-crossing predicate used by the request decoder.
package load_align_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_LO,
        S_WAIT_LO,
        S_REQ_HI,
        S_WAIT_HI,
        S_RESP
    } state_t;

    typedef logic [1:0] size_t;

    localparam size_t SZ_B = 2'd0;
    localparam size_t SZ_H = 2'd1;
    localparam size_t SZ_W = 2'd2;

    // True when the accessed bytes spill into the next 32-bit word.
    function automatic logic crosses_word(input size_t size, input logic [1:0] off);
        return ((size == SZ_H) && (off == 2'd3)) || ((size == SZ_W) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte-lane shifter and zero/sign extender for load results.
// hi_word must be zero when the access does not cross a word boundary.
module load_extract
    import load_align_pkg::*;
(
    input  logic [31:0] hi_word,
    input  logic [31:0] lo_word,
    input  logic [1:0]  off,
    input  size_t       size,
    input  logic        lu,
    output logic [31:0] data
);

    logic [63:0] shifted;
    logic [31:0] raw;

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch; the default arm below covers lw.
    always_comb begin
        shifted = {hi_word, lo_word} >> {off, 3'b000};
        raw     = shifted[31:0];
        case (size)
            SZ_B:    data = {{24{~lu & raw[7]}}, raw[7:0]};
            SZ_H:    data = {{16{~lu & raw[15]}}, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// Load request sequencer: issues one or two word reads over req/gnt/rvalid,
// then returns the aligned, extended result as a one-cycle response pulse.
module load_align_unit
    import load_align_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        lb,
    input  logic        lh,
    input  logic        lw,
    input  logic        lu,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    state_t      state;
    logic [1:0]  off_q;
    size_t       size_q;
    logic        lu_q;
    logic        cross_q;
    logic [31:0] lo_word;
    logic [31:0] hi_word;

    logic [1:0]  sel_count;
    size_t       req_size;
    logic        req_cross;
    logic        req_bad;
    logic [31:0] ext_lo;
    logic [31:0] ext_hi;
    logic [31:0] ext_data;

    assign sel_count = {1'b0, lb} + {1'b0, lh} + {1'b0, lw};
    assign req_size  = lw ? SZ_W : (lh ? SZ_H : SZ_B);
    assign req_cross = crosses_word(req_size, req_addr[1:0]);
    assign req_bad   = (sel_count != 2'd1) || (req_cross && !ALLOW_MISALIGNED);

    // Feed the extractor with the word arriving this cycle so the result can
    // be registered on the same edge that captures the final read.
    assign ext_lo = (state == S_WAIT_LO) ? mem_rdata : lo_word;
    assign ext_hi = (state == S_WAIT_HI) ? mem_rdata : (cross_q ? hi_word : 32'd0);

    load_extract u_extract (
        .hi_word (ext_hi),
        .lo_word (ext_lo),
        .off     (off_q),
        .size    (size_q),
        .lu      (lu_q),
        .data    (ext_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            off_q      <= '0;
            size_q     <= SZ_B;
            lu_q       <= 1'b0;
            cross_q    <= 1'b0;
            lo_word    <= '0;
            hi_word    <= '0;
            req_ready  <= 1'b1;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        off_q     <= req_addr[1:0];
                        size_q    <= req_size;
                        lu_q      <= lu;
                        cross_q   <= req_cross;
                        req_ready <= 1'b0;
                        if (req_bad) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                        end else begin
                            state    <= S_REQ_LO;
                            mem_req  <= 1'b1;
                            mem_addr <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                S_REQ_LO: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (mem_rvalid) begin
                        lo_word <= mem_rdata;
                        if (cross_q) begin
                            state    <= S_REQ_HI;
                            mem_req  <= 1'b1;
                            mem_addr <= mem_addr + 32'd4;
                        end else begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_data  <= ext_data;
                        end
                    end
                end
                S_REQ_HI: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (mem_rvalid) begin
                        hi_word    <= mem_rdata;
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= ext_data;
                    end
                end
                S_RESP: begin
                    state      <= S_IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_data  <= '0;
                    req_ready  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: one instance with misaligned splitting
// enabled, a second with it disabled for the rejection path.
module tb_load_align_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_valid_b;
    logic [31:0] req_addr;
    logic        lb, lh, lw, lu;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        tie_zero;
    logic [31:0] tie_zero32;

    logic        req_ready, mem_req, resp_valid, resp_err;
    logic [31:0] mem_addr, resp_data;
    logic        b_req_ready, b_mem_req, b_resp_valid, b_resp_err;
    logic [31:0] b_mem_addr, b_resp_data;

    int n_checks = 0;
    int n_fail   = 0;

    load_align_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .lb         (lb),
        .lh         (lh),
        .lw         (lw),
        .lu         (lu),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    load_align_unit #(.ALLOW_MISALIGNED(1'b0)) dut_strict (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid_b),
        .req_ready  (b_req_ready),
        .req_addr   (req_addr),
        .lb         (lb),
        .lh         (lh),
        .lw         (lw),
        .lu         (lu),
        .mem_req    (b_mem_req),
        .mem_addr   (b_mem_addr),
        .mem_gnt    (tie_zero),
        .mem_rvalid (tie_zero),
        .mem_rdata  (tie_zero32),
        .resp_valid (b_resp_valid),
        .resp_data  (b_resp_data),
        .resp_err   (b_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // sel = {lb, lh, lw, lu}; leaves the bench one cycle after the accept edge.
    task automatic issue(input logic [31:0] addr, input logic [3:0] sel, input bit strict);
        req_addr = addr;
        {lb, lh, lw, lu} = sel;
        if (strict) req_valid_b = 1'b1;
        else        req_valid   = 1'b1;
        @(negedge clk);
        req_valid   = 1'b0;
        req_valid_b = 1'b0;
        {lb, lh, lw, lu} = 4'b0;
    endtask

    task automatic serve_read(input string tag, input logic [31:0] exp_addr,
                              input logic [31:0] word, input int stall, input int rdelay);
        check({tag, " mem_req"}, 32'(mem_req), 32'd1);
        check({tag, " mem_addr"}, mem_addr, exp_addr);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, " mem_req held"}, 32'(mem_req), 32'd1);
            check({tag, " mem_addr stable"}, mem_addr, exp_addr);
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        for (int i = 0; i < rdelay; i++) begin
            check({tag, " mem_req dropped"}, 32'(mem_req), 32'd0);
            check({tag, " no early resp"}, 32'(resp_valid), 32'd0);
            @(negedge clk);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
    endtask

    task automatic expect_resp(input string tag, input logic [31:0] exp_data, input logic exp_err);
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, " resp_data"}, resp_data, exp_data);
        check({tag, " resp_err"}, 32'(resp_err), 32'(exp_err));
        @(negedge clk);
        check({tag, " single pulse"}, 32'(resp_valid), 32'd0);
        check({tag, " data cleared"}, resp_data, 32'd0);
        check({tag, " ready again"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_valid_b = 1'b0;
        req_addr = 32'd0;
        {lb, lh, lw, lu} = 4'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        tie_zero = 1'b0; tie_zero32 = 32'd0;

        repeat (2) @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_data", resp_data, 32'd0);
        check("reset resp_err", 32'(resp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // lbu / lb on the top byte of 0x80112233
        issue(32'h0000_1003, 4'b1001, 1'b0);
        check("lbu busy", 32'(req_ready), 32'd0);
        serve_read("lbu", 32'h0000_1000, 32'h8011_2233, 0, 0);
        expect_resp("lbu", 32'h0000_0080, 1'b0);
        issue(32'h0000_1003, 4'b1000, 1'b0);
        serve_read("lb", 32'h0000_1000, 32'h8011_2233, 0, 0);
        expect_resp("lb", 32'hFFFF_FF80, 1'b0);

        // lh / lhu on the upper halfword
        issue(32'h0000_2002, 4'b0100, 1'b0);
        serve_read("lh", 32'h0000_2000, 32'h8001_AAAA, 0, 0);
        expect_resp("lh", 32'hFFFF_8001, 1'b0);
        issue(32'h0000_2002, 4'b0101, 1'b0);
        serve_read("lhu", 32'h0000_2000, 32'h8001_AAAA, 0, 0);
        expect_resp("lhu", 32'h0000_8001, 1'b0);

        // Word-crossing lw, best-case latency T+5
        issue(32'h0000_3001, 4'b0010, 1'b0);
        serve_read("lw lo", 32'h0000_3000, 32'h4433_2211, 0, 0);
        serve_read("lw hi", 32'h0000_3004, 32'h8877_6655, 0, 0);
        expect_resp("lw cross", 32'h5544_3322, 1'b0);

        // Same load rejected when splitting is disabled
        issue(32'h0000_3001, 4'b0010, 1'b1);
        check("strict resp_valid", 32'(b_resp_valid), 32'd1);
        check("strict resp_err", 32'(b_resp_err), 32'd1);
        check("strict resp_data", b_resp_data, 32'd0);
        check("strict no mem_req", 32'(b_mem_req), 32'd0);
        @(negedge clk);
        check("strict pulse end", 32'(b_resp_valid), 32'd0);
        check("strict still no mem_req", 32'(b_mem_req), 32'd0);
        check("strict ready", 32'(b_req_ready), 32'd1);

        // lh at the top of memory with stalls; second read wraps to 0
        issue(32'hFFFF_FFFF, 4'b0100, 1'b0);
        serve_read("wrap lo", 32'hFFFF_FFFC, 32'hAB00_0000, 3, 2);
        serve_read("wrap hi", 32'h0000_0000, 32'h0000_00CD, 3, 2);
        expect_resp("wrap lh", 32'hFFFF_CDAB, 1'b0);

        // Illegal size select
        issue(32'h0000_4000, 4'b1100, 1'b0);
        check("illegal mem_req", 32'(mem_req), 32'd0);
        expect_resp("illegal", 32'd0, 1'b1);
        check("illegal no mem_req after", 32'(mem_req), 32'd0);
        issue(32'h0000_4000, 4'b0011, 1'b0);
        serve_read("lw aligned", 32'h0000_4000, 32'hDEAD_BEEF, 0, 0);
        expect_resp("lw aligned", 32'hDEAD_BEEF, 1'b0);

        // Asynchronous reset while waiting for read data
        issue(32'h0000_5000, 4'b0010, 1'b0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async rst mem_req", 32'(mem_req), 32'd0);
        check("async rst req_ready", 32'(req_ready), 32'd1);
        check("async rst mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        for (int i = 0; i < 3; i++) begin
            check("stray rvalid no resp", 32'(resp_valid), 32'd0);
            check("stray rvalid idle", 32'(req_ready), 32'd1);
            @(negedge clk);
        end

        // Unit still functional after the abandoned access
        issue(32'h0000_6001, 4'b1001, 1'b0);
        serve_read("post rst lbu", 32'h0000_6000, 32'h0000_FF00, 1, 1);
        expect_resp("post rst lbu", 32'h0000_00FF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
